// File: rtl/groestl_msg_feeder.sv
// rtl/groestl_msg_feeder.sv - Avalon-MM master feeding message words into a Groestl core and streaming out the digest
module groestl_msg_feeder #(
    parameter logic [4:0] CTRL_ADDR   = 5'h00,
    parameter logic [4:0] DATA_ADDR   = 5'h01,
    parameter logic [4:0] CLEAR_ADDR  = 5'h04,
    parameter logic [4:0] STATUS_ADDR = 5'h10,
    parameter logic [4:0] HASH_BASE   = 5'h08,
    parameter int         HASH_WORDS  = 8,
    parameter int         POLL_GAP    = 16,
    parameter int         POLL_MAX    = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_ctrl,
    input  logic [31:0] s_data,
    input  logic        s_last,
    output logic [4:0]  m_address,
    output logic [31:0] m_writedata,
    output logic [3:0]  m_byteenable,
    output logic        m_write,
    output logic        m_read,
    output logic        m_chipselect,
    input  logic [31:0] m_readdata,
    output logic        h_valid,
    input  logic        h_ready,
    output logic [31:0] h_data,
    output logic        h_last,
    output logic        busy,
    output logic        timeout_err
);

    localparam int PCW = $clog2(POLL_MAX + 1);
    localparam int GCW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [PCW-1:0] POLL_LIM = PCW'(POLL_MAX);
    localparam logic [GCW-1:0] GAP_LIM  = GCW'(POLL_GAP - 1);
    localparam logic [2:0]     LAST_IDX = 3'(HASH_WORDS - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_CTRL,
        S_GAP_CTRL,
        S_WR_DATA,
        S_GAP_DATA,
        S_NEXT,
        S_POLL_RD,
        S_POLL_WAIT,
        S_POLL_IDLE,
        S_CLEAR,
        S_GAP_CLEAR,
        S_HASH_RD,
        S_HASH_WAIT,
        S_HASH_OUT
    } state_t;

    state_t         state, state_n;
    logic [31:0]    ctrl_q, ctrl_n;
    logic [31:0]    data_q, data_n;
    logic           last_q, last_n;
    logic [PCW-1:0] poll_cnt, poll_n;
    logic [GCW-1:0] gap_cnt, gap_n;
    logic [2:0]     idx, idx_n;
    logic           s_ready_n;
    logic           m_write_n, m_read_n;
    logic [4:0]     m_address_n;
    logic [31:0]    m_writedata_n;
    logic           h_valid_n, h_last_n;
    logic [31:0]    h_data_n;
    logic           timeout_n;
    logic           take;

    assign take         = s_valid & s_ready;
    assign m_byteenable = 4'b1111;
    assign busy         = (state != S_IDLE);

    // Next-state and next-output decode; bus strobes are derived from the state being entered
    always_comb begin
        state_n       = state;
        ctrl_n        = ctrl_q;
        data_n        = data_q;
        last_n        = last_q;
        poll_n        = poll_cnt;
        gap_n         = gap_cnt;
        idx_n         = idx;
        h_valid_n     = h_valid;
        h_data_n      = h_data;
        h_last_n      = h_last;
        timeout_n     = timeout_err;
        s_ready_n     = 1'b0;
        m_write_n     = 1'b0;
        m_read_n      = 1'b0;
        m_address_n   = 5'h00;
        m_writedata_n = 32'h0;

        case (state)
            S_IDLE, S_NEXT: begin
                if (take) begin
                    state_n = S_WR_CTRL;
                    ctrl_n  = s_ctrl;
                    data_n  = s_data;
                    last_n  = s_last;
                    if (state == S_IDLE) begin
                        timeout_n = 1'b0;
                    end
                end
            end
            S_WR_CTRL:  state_n = S_GAP_CTRL;
            S_GAP_CTRL: state_n = S_WR_DATA;
            S_WR_DATA:  state_n = S_GAP_DATA;
            S_GAP_DATA: begin
                if (last_q) begin
                    state_n = S_POLL_RD;
                    poll_n  = PCW'(1);
                end else begin
                    state_n = S_NEXT;
                end
            end
            S_POLL_RD:  state_n = S_POLL_WAIT;
            S_POLL_WAIT: begin
                gap_n = '0;
                if (m_readdata[0]) begin
                    state_n = S_CLEAR;
                end else if (poll_cnt == POLL_LIM) begin
                    state_n   = S_IDLE;
                    timeout_n = 1'b1;
                end else begin
                    state_n = S_POLL_IDLE;
                end
            end
            S_POLL_IDLE: begin
                if (gap_cnt == GAP_LIM) begin
                    state_n = S_POLL_RD;
                    poll_n  = poll_cnt + 1'b1;
                end else begin
                    gap_n = gap_cnt + 1'b1;
                end
            end
            S_CLEAR:     state_n = S_GAP_CLEAR;
            S_GAP_CLEAR: begin
                idx_n   = 3'd0;
                state_n = S_HASH_RD;
            end
            S_HASH_RD:   state_n = S_HASH_WAIT;
            S_HASH_WAIT: begin
                h_valid_n = 1'b1;
                h_data_n  = m_readdata;
                h_last_n  = (idx == LAST_IDX);
                state_n   = S_HASH_OUT;
            end
            S_HASH_OUT: begin
                if (h_ready) begin
                    h_valid_n = 1'b0;
                    if (idx == LAST_IDX) begin
                        state_n = S_IDLE;
                    end else begin
                        idx_n   = idx + 1'b1;
                        state_n = S_HASH_RD;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        case (state_n)
            S_WR_CTRL: begin
                m_write_n     = 1'b1;
                m_address_n   = CTRL_ADDR;
                m_writedata_n = ctrl_n;
            end
            S_WR_DATA: begin
                m_write_n     = 1'b1;
                m_address_n   = DATA_ADDR;
                m_writedata_n = data_q;
            end
            S_CLEAR: begin
                m_write_n   = 1'b1;
                m_address_n = CLEAR_ADDR;
            end
            S_POLL_RD: begin
                m_read_n    = 1'b1;
                m_address_n = STATUS_ADDR;
            end
            S_HASH_RD: begin
                m_read_n    = 1'b1;
                m_address_n = HASH_BASE + {2'b00, idx_n};
            end
            S_IDLE, S_NEXT: s_ready_n = 1'b1;
            default: ;
        endcase
    end

    // State, datapath and registered outputs; reset aborts any transaction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            ctrl_q       <= 32'h0;
            data_q       <= 32'h0;
            last_q       <= 1'b0;
            poll_cnt     <= '0;
            gap_cnt      <= '0;
            idx          <= 3'd0;
            s_ready      <= 1'b0;
            m_write      <= 1'b0;
            m_read       <= 1'b0;
            m_chipselect <= 1'b0;
            m_address    <= 5'h00;
            m_writedata  <= 32'h0;
            h_valid      <= 1'b0;
            h_data       <= 32'h0;
            h_last       <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_n;
            ctrl_q       <= ctrl_n;
            data_q       <= data_n;
            last_q       <= last_n;
            poll_cnt     <= poll_n;
            gap_cnt      <= gap_n;
            idx          <= idx_n;
            s_ready      <= s_ready_n;
            m_write      <= m_write_n;
            m_read       <= m_read_n;
            m_chipselect <= m_write_n | m_read_n;
            m_address    <= m_address_n;
            m_writedata  <= m_writedata_n;
            h_valid      <= h_valid_n;
            h_data       <= h_data_n;
            h_last       <= h_last_n;
            timeout_err  <= timeout_n;
        end
    end

endmodule

// File: doc/groestl_msg_feeder.md
Name: groestl_msg_feeder

Overview:
- Avalon-MM master that drives the Groestl_Component slave port.
- Accepts message words on a valid/ready stream. Each word is paired with a control word, and both are written into the core.
- After the last word it polls the core until hash_ready is set, clears the flag, reads back the digest, and emits the digest words on an output stream.
- Sits between the host-side message source and the Groestl core, removing per-word software polling.

Parameters:
- CTRL_ADDR, 5'h00: core control register address.
- DATA_ADDR, 5'h01: core data register address.
- CLEAR_ADDR, 5'h04: hash_ready clear register address.
- STATUS_ADDR, 5'h10: core status register address; bit0 = hash_ready.
- HASH_BASE, 5'h08: address of digest word 0; word i is at HASH_BASE+i.
- HASH_WORDS, 8: number of 32-bit digest words read back (1..8).
- POLL_GAP, 16: idle cycles between status reads (>=1).
- POLL_MAX, 1024: status reads before timeout (>=1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- s_valid  in  1  input word valid.
- s_ready  out  1  input word accepted when s_valid&s_ready.
- s_ctrl  in  32  control word written to CTRL_ADDR ahead of this data word.
- s_data  in  32  message word written to DATA_ADDR.
- s_last  in  1  final word of the message.
- m_address  out  5  core address.
- m_writedata  out  32  core write data.
- m_byteenable  out  4  always 4'b1111.
- m_write  out  1  core write strobe.
- m_read  out  1  core read strobe.
- m_chipselect  out  1  core select; high whenever m_write or m_read is high.
- m_readdata  in  32  core read data, valid exactly 1 cycle after m_read.
- h_valid  out  1  digest word valid.
- h_ready  in  1  digest consumer ready.
- h_data  out  32  digest word.
- h_last  out  1  high on digest word HASH_WORDS-1.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky timeout flag; cleared when the next message is accepted.

Behaviour:
- Reset (synchronous): state=IDLE. These outputs are 0: s_ready, m_write, m_read, m_chipselect, m_address, m_writedata, h_valid, h_data, h_last, busy, timeout_err. m_byteenable is 4'b1111 at all times. Reset mid-transaction aborts immediately; no further bus cycles are issued and the core is not cleared.
- All bus strobes are registered, one cycle each, with a mandatory 1-cycle idle gap between consecutive strobes.
- IDLE:
  - s_ready=1.
  - On s_valid: latch ctrl/data/last, clear timeout_err, drop s_ready, go to WR_CTRL.
- WR_CTRL:
  - Issue write of the latched ctrl to CTRL_ADDR, then gap, then WR_DATA.
- WR_DATA:
  - Issue write of the latched data to DATA_ADDR, then gap.
  - If last: go to POLL_RD.
  - Otherwise: go to NEXT.
- NEXT:
  - s_ready=1.
  - On a handshake, latch the new word and go to WR_CTRL.
  - Waits indefinitely while s_valid=0.
- POLL_RD:
  - Issue read of STATUS_ADDR, increment the poll count, go to POLL_WAIT.
- POLL_WAIT:
  - Sample m_readdata.
  - If bit0=1: go to CLEAR.
  - Else if poll count==POLL_MAX: set timeout_err and go to IDLE. No digest is emitted and no clear is issued.
  - Else: go to POLL_IDLE.
- POLL_IDLE:
  - Count POLL_GAP cycles, then go to POLL_RD.
- CLEAR:
  - Issue write of 32'h0 to CLEAR_ADDR, then gap.
  - Reset the word index to 0, go to HASH_RD.
- HASH_RD:
  - Issue read of HASH_BASE+index, go to HASH_WAIT.
- HASH_WAIT:
  - Register m_readdata into h_data.
  - Assert h_valid with h_last=(index==HASH_WORDS-1), go to HASH_OUT.
- HASH_OUT:
  - h_valid holds, with h_data stable, until h_ready.
  - On handshake, drop h_valid.
  - If last: go to IDLE.
  - Otherwise: increment index, go to HASH_RD.
- h_ready asserted before h_valid has no effect. Backpressure stalls only the digest read-out, never the bus.
- The poll count resets to 0 on each entry to POLL_RD from WR_DATA.
- The next message is accepted only after the digest's h_last handshake, or after a timeout.
- Per word, the ctrl write strobe precedes the data write strobe by exactly 2 cycles.
- Minimum latency from s_valid (IDLE) to the first m_write is 1 cycle.

Test Plan:
- Two-word message: words {ctrl=32'h8, data=32'h80000000, last=0} and {ctrl=32'h0, data=32'hCC000000, last=1}, core model sets hash_ready on the 3rd poll -> exact bus sequence:
  - W@0=8, W@1=80000000, W@0=0, W@1=CC000000;
  - R@10 x3 with POLL_GAP spacing;
  - W@4=0;
  - R@08..R@0F;
  - 8 h_valid words equal to the model digest, h_last on the 8th.
- Output backpressure: h_ready low for 20 cycles on digest word 3 -> h_data stable; no bus read of word 4 until the handshake; order preserved.
- Timeout with POLL_MAX=4 and hash_ready never set -> exactly 4 status reads, then timeout_err=1, busy=0, no CLEAR write, no h_valid. The next accepted s_valid clears timeout_err.
- Input starvation: s_valid dropped for 50 cycles between words -> FSM waits in NEXT with no strobes; s_ready=1 throughout; resumes with W@0 on the next handshake.
- Reset asserted during HASH_RD of word 2 -> next cycle all strobes 0, h_valid=0, s_ready=0. The cycle after reset deasserts, s_ready=1 and a new message starts cleanly.
- Bus rules, checked across all tests: m_write and m_read are never both high; m_chipselect equals m_write|m_read; there is no pair of strobes on consecutive cycles; m_byteenable is 4'b1111 throughout.
